// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: steers the PC register, issues single-outstanding
// imem fetches and buffers returned {instr, pc} pairs in a 2-entry queue for decode.
module fetch_ctrl #(
    parameter int unsigned m = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [m-1:0] pc_cur,
    output logic [m-1:0] pc_next,
    output logic         imem_req,
    output logic [m-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [m-1:0] redirect_target,
    output logic         id_valid,
    output logic [31:0]  id_instr,
    output logic [m-1:0] id_pc,
    input  logic         id_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [1:0]   count;
    logic [1:0]   count_nx;
    logic         head;
    logic         wr_idx;
    logic [m-1:0] addr_q;
    logic         issue;
    logic         accept;
    logic         pop;

    logic [31:0]  q_instr [2];
    logic [m-1:0] q_pc    [2];

    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        accept    = 1'b0;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        id_valid  = 1'b0;
        pc_next   = '0;
        if (reset) begin
            id_valid = (count != 2'd0) && !redirect;
            pc_next  = pc_cur;
            case (state)
                IDLE: begin
                    imem_addr = pc_cur;
                    if ((count != 2'd2) && !redirect) begin
                        issue    = 1'b1;
                        imem_req = 1'b1;
                        if (imem_ack) begin
                            accept = 1'b1;
                        end else begin
                            state_nx = BUSY;
                        end
                    end
                end
                BUSY: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        state_nx = IDLE;
                        accept   = !redirect;
                    end else if (redirect) begin
                        state_nx = DROP;
                    end
                end
                DROP: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (redirect) begin
                pc_next = redirect_target;
            end else if (accept) begin
                pc_next = pc_cur + m'(4);
            end
        end
    end

    assign pop = id_valid && id_ready;

    // With one entry queued the free slot is the other one, so write index is head ^ count[0].
    assign wr_idx = head ^ count[0];

    always_comb begin
        count_nx = count + {1'b0, accept} - {1'b0, pop};
        if (redirect) begin
            count_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            head   <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (issue) begin
                addr_q <= pc_cur;
            end
            if (redirect) begin
                head <= 1'b0;
            end else if (pop) begin
                head <= ~head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_instr[wr_idx] <= imem_rdata;
            q_pc[wr_idx]    <= imem_addr;
        end
    end

    assign id_instr = q_instr[head];
    assign id_pc    = q_pc[head];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and variable-latency memory around the DUT,
// queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int pops = 0;

    int          lat_fixed = 0;
    int          ready_prob = 100;
    int          redir_prob = 0;
    logic        redir_now = 1'b0;
    logic [31:0] redir_tgt = '0;
    bit          mem_active = 1'b0;
    int          mem_cnt = 0;

    fetch_ctrl #(.m(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) pc_cur <= '0;
        else        pc_cur <= pc_next;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Environment: redirect/ready stimulus, then a memory that acks after 0..3 extra cycles.
    initial begin
        imem_rdata      = '0;
        redirect_target = '0;
        forever begin
            @(posedge clk);
            #1;
            if (redir_now) begin
                redirect        = 1'b1;
                redirect_target = redir_tgt;
                redir_now       = 1'b0;
            end else begin
                redirect        = int'($urandom_range(0, 99)) < redir_prob;
                redirect_target = $urandom & 32'hFFFF_FFFC;
            end
            id_ready = int'($urandom_range(0, 99)) < ready_prob;
            #1;
            imem_ack = 1'b0;
            if (!reset) begin
                mem_active = 1'b0;
            end else if (imem_req) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_cnt    = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                end
                if (mem_cnt == 0) begin
                    imem_ack   = 1'b1;
                    mem_active = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_rdata = imem_ack ? instr_of(imem_addr) : $urandom;
        end
    end

    // Reference model: expected fetch queue as a SystemVerilog queue of {instr, pc}.
    logic [63:0] mq[$];
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_pc = '0;

    always @(negedge clk) begin : model
        bit          can_issue;
        bit          exp_req;
        bit          exp_valid;
        bit          acc;
        logic [31:0] exp_addr;
        logic [31:0] exp_pcn;
        logic [63:0] head_e;
        if (!reset) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, id_valid}, 32'd0);
            chk("rst_pc_next", pc_next, 32'd0);
            mq.delete();
            m_out  = 1'b0;
            m_drop = 1'b0;
            m_pc   = '0;
        end else begin
            chk("pc_cur", pc_cur, m_pc);
            can_issue = !m_out && (mq.size() < 2) && !redirect;
            exp_req   = m_out || can_issue;
            exp_addr  = m_out ? m_addr : m_pc;
            exp_valid = (mq.size() > 0) && !redirect;
            acc       = imem_ack && !redirect && (can_issue || (m_out && !m_drop));
            exp_pcn   = redirect ? redirect_target : (acc ? m_pc + 32'd4 : m_pc);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            chk("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
            chk("pc_next", pc_next, exp_pcn);
            if (exp_req) chk("imem_addr", imem_addr, exp_addr);
            if (exp_valid) begin
                head_e = mq[0];
                chk("id_pc", id_pc, head_e[31:0]);
                chk("id_instr", id_instr, head_e[63:32]);
            end
            if (redirect) begin
                mq.delete();
            end else begin
                if (exp_valid && id_ready) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (acc) mq.push_back({instr_of(exp_addr), exp_addr});
            end
            if (imem_ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (can_issue) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end else if (m_out && redirect) begin
                m_drop = 1'b1;
            end
            m_pc = exp_pcn;
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #3;
        reset    = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Zero-wait memory, decode always ready: one instruction per cycle.
        lat_fixed  = 0;
        ready_prob = 100;
        redir_prob = 0;
        repeat (2) @(posedge clk);
        release_reset();
        @(negedge clk);
        chk("p1_req", {31'd0, imem_req}, 32'd1);
        chk("p1_addr", imem_addr, 32'h0);
        chk("p1_pc_next", pc_next, 32'h4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("p1_valid", {31'd0, id_valid}, 32'd1);
            chk("p1_id_pc", id_pc, 32'(4 * k));
            chk("p1_seq_pc_next", pc_next, 32'(4 * k + 8));
        end

        // Three-cycle wait: address stable, PC held until the ack cycle.
        lat_fixed = 3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("p2_req", {31'd0, imem_req}, 32'd1);
            chk("p2_addr", imem_addr, 32'h14);
            chk("p2_pc_next", pc_next, (k < 3) ? 32'h14 : 32'h18);
        end

        // Decode stalled: queue fills to two, fetch stops at 0x8.
        assert_reset();
        lat_fixed  = 0;
        ready_prob = 0;
        release_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("p3_full_req", {31'd0, imem_req}, 32'd0);
            chk("p3_full_pc_next", pc_next, 32'h8);
            chk("p3_full_id_pc", id_pc, 32'h0);
        end
        ready_prob = 100;
        @(negedge clk);
        chk("p3_pop0_id_pc", id_pc, 32'h0);
        chk("p3_pop0_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("p3_pop1_id_pc", id_pc, 32'h4);
        chk("p3_resume_addr", imem_addr, 32'h8);
        chk("p3_resume_pc_next", pc_next, 32'hC);

        // Redirect while a fetch is outstanding: the late response is dropped.
        assert_reset();
        lat_fixed = 3;
        release_reset();
        @(negedge clk);
        redir_now = 1'b1;
        redir_tgt = 32'h100;
        @(negedge clk);
        chk("p4_redir_valid", {31'd0, id_valid}, 32'd0);
        chk("p4_redir_pc_next", pc_next, 32'h100);
        chk("p4_redir_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        chk("p4_drop_addr", imem_addr, 32'h0);
        lat_fixed = 0;
        @(negedge clk);
        chk("p4_dropack_pc_next", pc_next, 32'h100);
        chk("p4_dropack_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("p4_target_addr", imem_addr, 32'h100);
        @(negedge clk);
        chk("p4_target_id_pc", id_pc, 32'h100);
        chk("p4_target_instr", id_instr, instr_of(32'h100));

        // Redirect coinciding with an ack while the queue holds an entry.
        assert_reset();
        lat_fixed  = 0;
        ready_prob = 0;
        release_reset();
        @(negedge clk);
        lat_fixed = 2;
        @(negedge clk);
        @(negedge clk);
        redir_now = 1'b1;
        redir_tgt = 32'h200;
        lat_fixed = 0;
        @(negedge clk);
        chk("p5_redir_pc_next", pc_next, 32'h200);
        chk("p5_redir_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("p5_empty_valid", {31'd0, id_valid}, 32'd0);
        chk("p5_target_addr", imem_addr, 32'h200);
        @(negedge clk);
        chk("p5_target_id_pc", id_pc, 32'h200);

        // Reset asserted mid-fetch: outputs fall immediately.
        assert_reset();
        lat_fixed  = 3;
        ready_prob = 100;
        release_reset();
        @(negedge clk);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("p6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("p6_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("p6_rst_pc_next", pc_next, 32'd0);
        lat_fixed = 0;
        repeat (2) @(posedge clk);

        // PC wraps past the top of the address space.
        release_reset();
        @(negedge clk);
        redir_now = 1'b1;
        redir_tgt = 32'hFFFF_FFFC;
        @(negedge clk);
        @(negedge clk);
        chk("p7_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("p7_wrap_pc_next", pc_next, 32'h0);
        @(negedge clk);
        chk("p7_wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // Randomized traffic with occasional resets.
        lat_fixed  = -1;
        ready_prob = 70;
        redir_prob = 8;
        pops       = 0;
        for (int r = 0; r < 3; r++) begin
            repeat (1500) @(posedge clk);
            assert_reset();
            release_reset();
        end
        repeat (1500) @(posedge clk);
        redir_prob = 0;
        repeat (10) @(posedge clk);
        chk("rand_progress", {31'd0, pops > 500}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
